service_uart_rx: RTL and testbench
==================================

SERVICE_UART_RX -- requirements
Module: service_uart_rx

Interface
REQ-001 Parameter DIV, default 556, clock cycles per UART bit (32 MHz / 57600 baud); legal range 8..65535.
REQ-002 Parameter DEPTH_LOG2, default 4, log2 of receive FIFO depth (16 entries).
REQ-003 i_clk  input  1  single clock; all state on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_rx  input  1  asynchronous serial line from the SoC GPIO output q; 8N1 framing, idle high.
REQ-006 o_data  output  8  byte at FIFO head; valid only while o_valid=1.
REQ-007 o_valid  output  1  FIFO non-empty.
REQ-008 i_ready  input  1  consumer accepts o_data when o_valid&i_ready.
REQ-009 o_level  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.
REQ-010 o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 o_overflow  output  1  one-cycle pulse: completed byte dropped, FIFO full.
REQ-012 o_busy  output  1  receiver FSM not in IDLE.

Function
REQ-013 i_rx SHALL pass through a 2-flop synchronizer before use; both flops reset to 1.
REQ-014 FSM states: IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: on synchronized falling edge (prev=1, cur=0) load bit counter with DIV/2-1, go START.
REQ-016 START: at counter zero sample line; 0 -> load DIV-1, bit index 0, go DATA; 1 -> glitch, return IDLE, nothing reported.
REQ-017 DATA: at each counter zero sample into shift register LSB first, reload DIV-1; after bit index 7 go STOP.
REQ-018 STOP: at counter zero sample; 1 -> push byte, go IDLE; 0 -> pulse o_frame_err, discard byte, go BREAK.
REQ-019 BREAK: remain until synchronized line reads 1, then IDLE; falling edges ignored in BREAK.
REQ-020 Total sample point of bit n (n=0 start .. 9 stop) SHALL be DIV/2 + n*DIV cycles after the synchronized falling edge, integer division truncating.
REQ-021 FIFO push occurs in the cycle after the stop-bit sample; o_valid SHALL rise the following cycle when FIFO was empty (2 cycles after stop sample).
REQ-022 FIFO is show-ahead: o_data equals head entry combinationally from storage whenever o_valid=1.
REQ-023 Pop when o_valid&i_ready; pop with o_valid=0 has no effect.
REQ-024 Push when full and no pop in same cycle: byte dropped, o_overflow pulses, contents unchanged.
REQ-025 Push and pop in same cycle when full: both performed, no overflow, o_level unchanged.
REQ-026 Push and pop in same cycle when empty: push performed, pop ignored, o_level becomes 1.
REQ-027 Read/write pointers DEPTH_LOG2+1 bits, wrap modulo 2^(DEPTH_LOG2+1); full/empty from MSB compare.
REQ-028 o_busy SHALL be 1 in START, DATA, STOP, BREAK.

Reset
REQ-029 While i_rst_n=0: FSM IDLE, counters 0, shift register 0, FIFO pointers 0, o_valid 0, o_level 0, o_frame_err 0, o_overflow 0, o_busy 0; FIFO storage not reset.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no push or error; after release a frame is recognized only on a new falling edge.

Structure
REQ-031 Package service_uart_pkg holds the FSM state enum and default DIV constant.
REQ-032 FIFO SHALL be a sub-module service_uart_fifo (parameter DEPTH_LOG2, width 8, push/pop/full/empty/level ports).
REQ-033 Implementation target 150-300 lines total, no vendor primitives.

Verification (bench uses DIV=16, DEPTH_LOG2=2)
REQ-034 Send 0x55 then 0xA3 at exact baud, i_ready=1 -> o_data 0x55 then 0xA3, each o_valid rising 2 cycles after its stop sample; no error pulses.
REQ-035 Low pulse of 5 cycles on idle line -> returns IDLE after 8 cycles, no push, o_level stays 0.
REQ-036 Frame 0x3C with stop bit held low for 30 cycles -> one o_frame_err pulse, o_level 0, o_busy 1 until line high, next frame 0x01 received correctly.
REQ-037 i_ready=0, send 5 bytes 0x10..0x14 -> o_level 4, one o_overflow pulse on 5th; drain yields 0x10..0x13.
REQ-038 FIFO full, assert i_ready exactly in push cycle of 0x99 -> no overflow, o_level stays 4, 0x99 read last.
REQ-039 Assert i_rst_n=0 during DATA bit 4 of 0xFF -> after release o_valid 0, o_busy 0; following frame 0x42 received intact.

Source files
------------

// File: rtl/service_uart_pkg.sv
// Shared types and constants for the service UART receiver.
package service_uart_pkg;

  // 32 MHz core clock / 57600 baud
  localparam int DIV_DEFAULT = 556;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

endpackage

// File: rtl/service_uart_fifo.sv
// Show-ahead byte FIFO. Pointers carry one extra wrap bit so full and
// empty are distinguished by comparing MSBs. Storage is left unreset.
module service_uart_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_push,
  input  logic [7:0]          i_wdata,
  input  logic                i_pop,
  output logic [7:0]          o_rdata,
  output logic                o_full,
  output logic                o_empty,
  output logic [DEPTH_LOG2:0] o_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          mem [DEPTH];
  logic [DEPTH_LOG2:0] wptr, rptr;
  logic                do_push, do_pop;

  assign o_empty = (wptr == rptr);
  assign o_full  = (wptr[DEPTH_LOG2] != rptr[DEPTH_LOG2]) &&
                   (wptr[DEPTH_LOG2-1:0] == rptr[DEPTH_LOG2-1:0]);
  assign o_level = wptr - rptr;
  assign o_rdata = mem[rptr[DEPTH_LOG2-1:0]];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push that coincides with a pop; popping an empty FIFO does nothing.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  // Pointer update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wptr[DEPTH_LOG2-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/service_uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing-error/break handling
// and a show-ahead receive FIFO.
module service_uart_rx
  import service_uart_pkg::*;
#(
  parameter int DIV        = DIV_DEFAULT,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_rx,
  output logic [7:0]          o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [DEPTH_LOG2:0] o_level,
  output logic                o_frame_err,
  output logic                o_overflow,
  output logic                o_busy
);

  localparam logic [15:0] HALF_LD = 16'(DIV / 2 - 1);
  localparam logic [15:0] BIT_LD  = 16'(DIV - 1);

  rx_state_e   state, nxt;
  logic        rx_s1, rx_s2, rx_prev;
  logic        fall, tick;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        ld_half, ld_bit, shift_en, stop_ok, stop_bad;
  logic        push_q, ferr_q;
  logic        fifo_full, fifo_empty;

  // Two-flop synchronizer plus one history flop for edge detect; idle-high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= i_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign fall = rx_prev & ~rx_s2;
  assign tick = (cnt == 16'd0);

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  // FSM next state
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (fall) nxt = ST_START;
      ST_START: if (tick) nxt = rx_s2 ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick && bit_idx == 3'd7) nxt = ST_STOP;
      ST_STOP:  if (tick) nxt = rx_s2 ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s2) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: counter loads, shift strobe and stop-bit verdict
  always_comb begin
    o_busy   = (state != ST_IDLE);
    ld_half  = (state == ST_IDLE) & fall;
    ld_bit   = ((state == ST_START) & tick & ~rx_s2) | ((state == ST_DATA) & tick);
    shift_en = (state == ST_DATA) & tick;
    stop_ok  = (state == ST_STOP) & tick & rx_s2;
    stop_bad = (state == ST_STOP) & tick & ~rx_s2;
  end

  // Bit timer, bit index, LSB-first shift register, registered push/error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      push_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (ld_half)         cnt <= HALF_LD;
      else if (ld_bit)     cnt <= BIT_LD;
      else if (!tick)      cnt <= cnt - 16'd1;
      if ((state == ST_START) && tick) bit_idx <= 3'd0;
      else if (shift_en)               bit_idx <= bit_idx + 3'd1;
      if (shift_en) shreg <= {rx_s2, shreg[7:1]};
      push_q <= stop_ok;
      ferr_q <= stop_bad;
    end
  end

  service_uart_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push_q),
    .i_wdata (shreg),
    .i_pop   (i_ready),
    .o_rdata (o_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  assign o_valid     = ~fifo_empty;
  assign o_frame_err = ferr_q;
  // A full FIFO is never empty, so o_valid&i_ready here means a slot frees up
  assign o_overflow  = push_q & fifo_full & ~(o_valid & i_ready);

endmodule

// File: tb/tb_service_uart_rx.sv
// Bench for service_uart_rx: table of frames plus hand-written corner cases,
// received bytes checked against a queue of expected bytes.
module tb_service_uart_rx;

  localparam int DIV = 16;
  localparam int DL  = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_rx = 1'b1;
  logic          i_ready = 1'b0;
  logic [7:0]    o_data;
  logic          o_valid;
  logic [DL:0]   o_level;
  logic          o_frame_err, o_overflow, o_busy;

  service_uart_rx #(.DIV(DIV), .DEPTH_LOG2(DL)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_level     (o_level),
    .o_frame_err (o_frame_err),
    .o_overflow  (o_overflow),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         ferr_cnt = 0;
  int         ovf_cnt = 0;
  int         rise_cyc = -1;
  logic       prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: sample mid-low-phase, count pulses, note o_valid rise, score pops
  always @(negedge i_clk) begin
    #2;
    if (o_frame_err) ferr_cnt++;
    if (o_overflow)  ovf_cnt++;
    if (o_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = o_valid;
    if (o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got 0x%0h expected none", o_data);
      end else begin
        chk("rx_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // Drive one 8N1 frame starting at the current negedge; stop_low>0 holds the
  // stop bit low for that many cycles before releasing the line.
  task automatic send_frame(input logic [7:0] b, input int stop_low, output int base);
    base = cyc;
    i_rx = 1'b0;
    repeat (DIV) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (DIV) @(negedge i_clk);
    end
    if (stop_low > 0) begin
      i_rx = 1'b0;
      repeat (stop_low - 1) @(negedge i_clk);
      chk("busy_in_break", o_busy, 1);
      @(negedge i_clk);
    end
    i_rx = 1'b1;
    repeat (DIV + 4) @(negedge i_clk);
  endtask

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    bit         exp_push;
    int         exp_ferr;
  } vec_t;

  vec_t vt[4];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int base, b2, f0, o0;
    vt[0] = '{8'h55, 0,  1'b1, 0};
    vt[1] = '{8'hA3, 0,  1'b1, 0};
    vt[2] = '{8'h3C, 30, 1'b0, 1};
    vt[3] = '{8'h01, 0,  1'b1, 0};

    // Reset
    #1 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_level", o_level, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_ferr", o_frame_err, 0);
    chk("rst_ovf", o_overflow, 0);
    i_rst_n = 1'b1;
    repeat (4) @(negedge i_clk);

    // Table-driven frames, consumer always ready
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      f0 = ferr_cnt;
      o0 = ovf_cnt;
      rise_cyc = -1;
      if (vt[k].exp_push) exp_q.push_back(vt[k].data);
      send_frame(vt[k].data, vt[k].stop_low, base);
      chk("ferr_pulses", ferr_cnt - f0, vt[k].exp_ferr);
      chk("ovf_pulses", ovf_cnt - o0, 0);
      if (vt[k].exp_push) chk("valid_rise_delay", rise_cyc - base, 156);
      else                chk("no_valid_rise", rise_cyc, -1);
      chk("busy_after_frame", o_busy, 0);
      chk("level_after_frame", o_level, 0);
    end

    // Start-bit glitch: 5-cycle low pulse
    f0 = ferr_cnt;
    base = cyc;
    i_rx = 1'b0;
    repeat (5) @(negedge i_clk);
    i_rx = 1'b1;
    while (cyc < base + 10) @(negedge i_clk);
    chk("glitch_busy_before_sample", o_busy, 1);
    @(negedge i_clk);
    chk("glitch_idle_after_sample", o_busy, 0);
    repeat (20) @(negedge i_clk);
    chk("glitch_level", o_level, 0);
    chk("glitch_valid", o_valid, 0);
    chk("glitch_ferr", ferr_cnt - f0, 0);

    // Overflow: five bytes into a four-entry FIFO with consumer stalled
    i_ready = 1'b0;
    o0 = ovf_cnt;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_q.push_back(8'h10 + 8'(k));
      send_frame(8'h10 + 8'(k), 0, base);
    end
    chk("ovf_pulse_count", ovf_cnt - o0, 1);
    chk("ovf_level_full", o_level, 4);
    chk("ovf_valid", o_valid, 1);
    i_ready = 1'b1;
    repeat (8) @(negedge i_clk);
    chk("ovf_drained_level", o_level, 0);
    chk("ovf_drained_queue", exp_q.size(), 0);

    // Full FIFO, pop lands exactly in the push cycle of 0x99
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'h20 + 8'(k));
      send_frame(8'h20 + 8'(k), 0, base);
    end
    chk("simul_pre_level", o_level, 4);
    o0 = ovf_cnt;
    b2 = cyc;
    exp_q.push_back(8'h99);
    fork
      send_frame(8'h99, 0, base);
      begin
        while (cyc < b2 + 155) @(negedge i_clk);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
      end
    join
    chk("simul_no_ovf", ovf_cnt - o0, 0);
    chk("simul_level", o_level, 4);
    i_ready = 1'b1;
    repeat (8) @(negedge i_clk);
    chk("simul_drained_level", o_level, 0);
    chk("simul_drained_queue", exp_q.size(), 0);

    // Reset in the middle of data bit 4 of 0xFF
    f0 = ferr_cnt;
    i_rx = 1'b0;
    repeat (DIV) @(negedge i_clk);
    i_rx = 1'b1;
    repeat (4 * DIV + DIV / 2) @(negedge i_clk);
    chk("midrst_busy_before", o_busy, 1);
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("midrst_busy_in_reset", o_busy, 0);
    i_rst_n = 1'b1;
    repeat (3 * DIV) @(negedge i_clk);
    chk("midrst_valid_after", o_valid, 0);
    chk("midrst_busy_after", o_busy, 0);
    chk("midrst_ferr", ferr_cnt - f0, 0);
    rise_cyc = -1;
    exp_q.push_back(8'h42);
    send_frame(8'h42, 0, base);
    chk("midrst_next_rise", rise_cyc - base, 156);
    chk("midrst_next_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
